bcd_entry: RTL
==============

# bcd_entry

Two-digit decimal entry block for the DE-board switch/display path: the inverse of the binary-to-decimal display path. The user keys in a tens digit, then a units digit, on SW[3:0], confirming each with a debounced push-button. The block converts the two BCD digits to a 7-bit binary value (0–99), echoes the digits on HEX1/HEX0 and shows the binary result on LEDR.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before a key level change is accepted (20 ms at 50 MHz). Must be ≥ 1.
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high; resets all state.
- SW  in  4  digit value (BCD, 0–9 valid).
- KEY  in  2  push-buttons, active-low, asynchronous to CLOCK_50. KEY[0] = enter, KEY[1] = clear.
- HEX0  out  7  units-digit display, active-low segments.
- HEX1  out  7  tens-digit display, active-low segments.
- LEDR  out  10  [6:0] binary value, [7] valid, [8] error, [9] awaiting-units.

## Operation
- **Key path (per key, identical):**
  - 2-flop synchronizer.
  - Debouncer holds a debounced level and a counter.
  - Counter clears whenever the synced level equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 with the levels still differing, the debounced level flips and the counter clears.
  - A press pulse (one cycle) fires on a debounced 1→0 transition. Release generates nothing.
  - Held keys produce exactly one pulse.
- **FSM states:** S_TENS, S_UNITS, S_DONE.
  - **S_TENS**, enter pulse:
    - SW ≤ 9: tens←SW, err←0, go to S_UNITS.
    - SW > 9: err←1, stay; tens unchanged.
  - **S_UNITS**, enter pulse:
    - SW ≤ 9: units←SW, value←tens·10+units, valid←1, err←0, go to S_DONE.
    - SW > 9: err←1, stay.
  - **S_DONE**, enter pulse: behaves as S_TENS (starts a new number). On acceptance, valid←0, value←0, units cleared, go to S_UNITS. An invalid digit sets err and leaves value/valid intact.
  - **Clear pulse, any state:** tens, units, value, valid and err all ←0; go to S_TENS.
  - **Simultaneous clear and enter pulses:** clear wins; enter is discarded.
- **Arithmetic:** value = {tens,3'b000} + {tens,1'b0} + units, computed at 7 bits. Maximum is 99, so no overflow.
- **Displays (active-low, blank = 7'h7F):**
  - HEX1 shows tens in S_UNITS and S_DONE; blank in S_TENS.
  - HEX0 shows units in S_DONE; blank otherwise.
  - Digit encodings 0–9 use the team's standard seven-segment pattern.
- **LEDR:** [6:0]=value, [7]=valid, [8]=err, [9]=1 iff state is S_UNITS.

## Timing
- **Reset values:**
  - State S_TENS; tens, units, value = 0; valid = 0, err = 0.
  - Debounced levels = 1 (released); debounce counters = 0; synchronizer flops = 1.
  - HEX0 = HEX1 = 7'h7F; LEDR = 10'b0.
- **Reset mid-operation** (including mid-debounce) returns to these values immediately. The first press after reset requires a full debounce period.
- **Latency:** a KEY edge held stable produces its press pulse DEBOUNCE_CYCLES+2 cycles after the edge (2 sync cycles + debounce count). FSM registers and LEDR/HEX update on the following clock edge.
- **SW sampling:** SW is sampled in the cycle the press pulse is high. SW must be stable at that point; SW is not synchronized.
- **Glitches:** a bounce shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no pulse.
- **Outputs:** all outputs are registered or decoded from registers only; no combinational path from SW or KEY to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert reset mid-count with KEY[0]=0 → HEX0=HEX1=7'h7F, LEDR=0. After release, no pulse until KEY[0] has been stable low for 4 cycles past the synchronizer.
- **Normal entry:** SW=7, press enter; SW=3, press enter → HEX1 shows 7, HEX0 shows 3, LEDR[6:0]=73 (7'h49), LEDR[7]=1, LEDR[9]=0.
- **Invalid digit:** in S_TENS, SW=12 and press enter → LEDR[8]=1, HEX1 blank, state unchanged. Then SW=9, press enter → LEDR[8]=0, LEDR[9]=1, HEX1 shows 9.
- **Bounce:** KEY[0] toggles low for 2 cycles, then high, three times, then settles low → exactly one accepted digit. Holding KEY[0] low for 100 cycles produces no second digit.
- **Clear priority:** in S_UNITS with tens=5, press both keys so the two pulses coincide → state S_TENS, tens=0, LEDR=0, HEX1 blank.
- **Boundary and restart:** enter 9, 9 → LEDR[6:0]=99. Enter 0, 0 → LEDR[6:0]=0, valid=1. From S_DONE, enter SW=4 → valid=0, LEDR[6:0]=0, HEX1 shows 4, HEX0 blank.

Source files
------------

// File: rtl/bcd_entry.sv
// Two-digit decimal entry: debounced enter/clear keys, BCD digit capture,
// BCD->binary conversion, seven-segment echo of the digits and LED readout.

// Per-key path: 2-flop synchronizer, counter debouncer, one-cycle press pulse.
module bcd_entry_key #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Sync, count disagreement cycles, flip level once it has held long enough
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_db    <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_db    <= r_sync[1];
                r_cnt   <= '0;
                // only the released->pressed flip produces a pulse
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

module bcd_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] SW,
    input  logic [1:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [9:0] LEDR
);
    localparam int NUM_KEYS = 2;

    typedef enum logic [1:0] {S_TENS, S_UNITS, S_DONE} state_t;

    logic [NUM_KEYS-1:0] w_press;
    logic                w_enter;
    logic                w_clear;
    logic                w_digit_ok;
    logic [6:0]          w_value_next;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic [6:0] r_value;
    logic       r_valid;
    logic       r_err;

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            bcd_entry_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
                .i_clk   (CLOCK_50),
                .i_rst   (reset),
                .i_key_n (KEY[g]),
                .o_press (w_press[g])
            );
        end
    endgenerate

    assign w_enter    = w_press[0];
    assign w_clear    = w_press[1];
    assign w_digit_ok = (SW <= 4'd9);

    // tens*10 + units as shift-and-add, 7 bits is enough for 99
    always_comb begin
        w_value_next = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, SW};
    end

    // Entry FSM; clear has priority over a coincident enter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_TENS;
            r_tens  <= '0;
            r_units <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_clear) begin
            r_state <= S_TENS;
            r_tens  <= '0;
            r_units <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_enter) begin
            case (r_state)
                S_UNITS: begin
                    if (w_digit_ok) begin
                        r_units <= SW;
                        r_value <= w_value_next;
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    // S_TENS and S_DONE both start a new number
                    if (w_digit_ok) begin
                        r_tens  <= SW;
                        r_units <= '0;
                        r_value <= '0;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_UNITS;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Displays and LEDs decode only from registers
    always_comb begin
        HEX1 = (r_state != S_TENS) ? seg7(r_tens) : 7'h7F;
        HEX0 = (r_state == S_DONE) ? seg7(r_units) : 7'h7F;
        LEDR = {(r_state == S_UNITS), r_err, r_valid, r_value};
    end
endmodule
